multi_cycle_ctrl: RTL and testbench
===================================

Name: multi_cycle_ctrl

Overview:
- Moore-style main control FSM for the multi-cycle MIPS datapath; sits directly upstream of the ALU controller.
- Sequences each instruction through fetch / decode / execute / memory / writeback.
- Each cycle it drives ALUOp_o (the 3-bit op class the ALU controller consumes) plus all datapath mux selects and write enables.
- Memory accesses use a ready handshake, so FETCH and memory states stall for variable latency.

Parameters:
- OP_W, 6, opcode width (instr[31:26])
- ST_W, 4, state register width

Ports:
- clk_i  input  1  clock; all state updates on the rising edge
- rst_i  input  1  reset; synchronous, active-low
- opcode_i  input  6  opcode of the latched instruction register
- mem_ready_i  input  1  memory completes the current read/write this cycle
- ALUOp_o  output  3  op class: 000 add, 001 sub, 010 R-type (use funct), 011 addi, 111 slti
- ALUSrcA_o  output  1  0 = PC, 1 = register A
- ALUSrcB_o  output  2  00 = register B, 01 = constant 4, 10 = sign-extended imm, 11 = sign-extended imm<<2
- IorD_o  output  1  memory address: 0 = PC, 1 = ALUOut
- MemRead_o  output  1  memory read request
- MemWrite_o  output  1  memory write request
- IRWrite_o  output  1  latch instruction register
- MemtoReg_o  output  1  writeback data: 0 = ALUOut, 1 = MDR
- RegDst_o  output  1  destination register: 0 = rt, 1 = rd
- RegWrite_o  output  1  register file write enable
- PCWrite_o  output  1  unconditional PC write
- PCWriteCond_o  output  1  PC write if ALU zero
- PCSource_o  output  2  00 = ALU result, 01 = ALUOut, 10 = jump target
- illegal_o  output  1  one-cycle pulse in DECODE on an unsupported opcode
- state_o  output  4  current state, for debug

Behaviour:
- States: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_RD=3, MEM_WB=4, MEM_WR=5, R_EXE=6, R_WB=7, BRANCH=8, I_EXE=9, I_WB=10, JUMP=11.
- Reset: rst_i low at a clock edge sets state to FETCH. While rst_i is low, every enable output (MemRead, MemWrite, IRWrite, RegWrite, PCWrite, PCWriteCond, illegal) is forced to 0. Selects are 0, except ALUSrcB=01. Reset mid-instruction abandons it with no register or PC write.
- Unlisted outputs are 0 in every state.
- FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=000, PCSource=00.
  - IRWrite=1 and PCWrite=1 only in the cycle mem_ready_i=1; that cycle moves to DECODE.
  - Otherwise stay in FETCH.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=000 (branch target into ALUOut). Next state by opcode:
  - 35 (lw) or 43 (sw) -> MEM_ADDR
  - 0 (R-type) -> R_EXE
  - 4 (beq) -> BRANCH
  - 8 (addi) or 10 (slti) -> I_EXE
  - 2 (j) -> JUMP
  - any other opcode -> FETCH with illegal_o=1
- MEM_ADDR: ALUSrcA=1, ALUSrcB=10, ALUOp=000. Next: lw -> MEM_RD, sw -> MEM_WR.
- MEM_RD: MemRead=1, IorD=1. Stall until mem_ready_i, then -> MEM_WB.
- MEM_WR: MemWrite=1, IorD=1. Stall until mem_ready_i, then -> FETCH.
- MEM_WB: RegWrite=1, MemtoReg=1, RegDst=0. Then -> FETCH.
- R_EXE: ALUSrcA=1, ALUSrcB=00, ALUOp=010. Then -> R_WB.
- R_WB: RegWrite=1, RegDst=1, MemtoReg=0. Then -> FETCH.
- I_EXE: ALUSrcA=1, ALUSrcB=10; ALUOp=011 for addi, 111 for slti. Then -> I_WB.
- I_WB: RegWrite=1, RegDst=0, MemtoReg=0. Then -> FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=001, PCWriteCond=1, PCSource=01. Then -> FETCH.
- JUMP: PCWrite=1, PCSource=10. Then -> FETCH.
- opcode_i is sampled in DECODE, MEM_ADDR and I_EXE. IR is stable there because IRWrite fires only in FETCH.
- Cycles per instruction with zero wait:
  - lw 5, sw 4, R/addi/slti 4, beq 3, j 3.
  - Each wait cycle on mem_ready_i adds one.
- mem_ready_i is ignored in non-memory states.
- Unreachable state codes 12–15 -> FETCH with all enables 0.

Decomposition:
- Shared package `mips_ctrl_pkg`:
  - state localparams
  - opcode constants OP_RTYPE=0, OP_J=2, OP_BEQ=4, OP_ADDI=8, OP_SLTI=10, OP_LW=35, OP_SW=43
  - ALUOp encodings ALUOP_ADD=000, ALUOP_SUB=001, ALUOP_R=010, ALUOP_ADDI=011, ALUOP_SLTI=111
  - ALUSrcB and PCSource select codes
- The ALU controller imports the same ALUOp constants.
- Single module, no sub-module: a next-state block plus a registered state and a combinational output decode.

Test Plan:
- Reset: rst_i=0 for 2 cycles with mem_ready_i=1 -> state_o=0, all enables 0. Release -> FETCH with MemRead=1, ALUSrcB=01, ALUOp=000.
- lw, opcode 35, mem_ready_i held 1 -> states 0,1,2,3,4,0 over 5 cycles. RegWrite=1 and MemtoReg=1 only in state 4. ALUOp=000 in states 0/1/2.
- R-type, opcode 0, with 2 wait cycles in FETCH (mem_ready_i=0,0,1) -> IRWrite and PCWrite pulse exactly once, on cycle 3. ALUOp=010 in R_EXE. RegWrite=1 with RegDst=1 in R_WB.
- slti then addi, opcodes 10 then 8 -> ALUOp=111 in the first I_EXE, 011 in the second. I_WB RegWrite=1, RegDst=0.
- beq and j, opcodes 4 then 2 -> BRANCH: PCWriteCond=1, PCSource=01, ALUOp=001. JUMP: PCWrite=1, PCSource=10. Each instruction is 3 cycles.
- Illegal opcode 63 -> illegal_o=1 for exactly one cycle in DECODE, next state FETCH, no RegWrite or MemWrite. sw with rst_i=0 asserted in MEM_WR -> MemWrite drops that cycle, state_o=0 next.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// ============================================================
// mips_ctrl_pkg : shared encodings for the multi-cycle MIPS control path
// Rev 1.0
// ============================================================
`default_nettype none

package mips_ctrl_pkg;

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEM_ADDR = 4'd2;
  localparam logic [3:0] S_MEM_RD   = 4'd3;
  localparam logic [3:0] S_MEM_WB   = 4'd4;
  localparam logic [3:0] S_MEM_WR   = 4'd5;
  localparam logic [3:0] S_R_EXE    = 4'd6;
  localparam logic [3:0] S_R_WB     = 4'd7;
  localparam logic [3:0] S_BRANCH   = 4'd8;
  localparam logic [3:0] S_I_EXE    = 4'd9;
  localparam logic [3:0] S_I_WB     = 4'd10;
  localparam logic [3:0] S_JUMP     = 4'd11;

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_J     = 6'd2;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_ADDI  = 6'd8;
  localparam logic [5:0] OP_SLTI  = 6'd10;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;

  localparam logic [2:0] ALUOP_ADD  = 3'b000;
  localparam logic [2:0] ALUOP_SUB  = 3'b001;
  localparam logic [2:0] ALUOP_R    = 3'b010;
  localparam logic [2:0] ALUOP_ADDI = 3'b011;
  localparam logic [2:0] ALUOP_SLTI = 3'b111;

  localparam logic [1:0] SRCB_REG    = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  function automatic logic op_supported(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_J) || (op == OP_BEQ) || (op == OP_ADDI) ||
           (op == OP_SLTI) || (op == OP_LW) || (op == OP_SW);
  endfunction

endpackage

`default_nettype wire

// File: rtl/multi_cycle_ctrl.sv
// ============================================================
// multi_cycle_ctrl : Moore main control FSM for the multi-cycle MIPS datapath
// Rev 1.0
// ============================================================
`default_nettype none

module multi_cycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int OP_W = 6,
  parameter int ST_W = 4
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [OP_W-1:0] opcode_i,
  input  logic            mem_ready_i,
  output logic [2:0]      ALUOp_o,
  output logic            ALUSrcA_o,
  output logic [1:0]      ALUSrcB_o,
  output logic            IorD_o,
  output logic            MemRead_o,
  output logic            MemWrite_o,
  output logic            IRWrite_o,
  output logic            MemtoReg_o,
  output logic            RegDst_o,
  output logic            RegWrite_o,
  output logic            PCWrite_o,
  output logic            PCWriteCond_o,
  output logic [1:0]      PCSource_o,
  output logic            illegal_o,
  output logic [ST_W-1:0] state_o
);

  logic [ST_W-1:0] state;
  logic [ST_W-1:0] state_nxt;

  always_ff @(posedge clk_i) begin
    if (!rst_i) state <= S_FETCH;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = S_FETCH;
    case (state)
      S_FETCH:    state_nxt = mem_ready_i ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode_i)
          OP_LW, OP_SW:     state_nxt = S_MEM_ADDR;
          OP_RTYPE:         state_nxt = S_R_EXE;
          OP_BEQ:           state_nxt = S_BRANCH;
          OP_ADDI, OP_SLTI: state_nxt = S_I_EXE;
          OP_J:             state_nxt = S_JUMP;
          default:          state_nxt = S_FETCH;
        endcase
      end
      S_MEM_ADDR: begin
        if (opcode_i == OP_LW)      state_nxt = S_MEM_RD;
        else if (opcode_i == OP_SW) state_nxt = S_MEM_WR;
        else                        state_nxt = S_FETCH;
      end
      S_MEM_RD:   state_nxt = mem_ready_i ? S_MEM_WB : S_MEM_RD;
      S_MEM_WR:   state_nxt = mem_ready_i ? S_FETCH : S_MEM_WR;
      S_R_EXE:    state_nxt = S_R_WB;
      S_I_EXE:    state_nxt = S_I_WB;
      default:    state_nxt = S_FETCH;
    endcase
  end

  always_comb begin
    ALUOp_o       = ALUOP_ADD;
    ALUSrcA_o     = 1'b0;
    ALUSrcB_o     = SRCB_REG;
    IorD_o        = 1'b0;
    MemRead_o     = 1'b0;
    MemWrite_o    = 1'b0;
    IRWrite_o     = 1'b0;
    MemtoReg_o    = 1'b0;
    RegDst_o      = 1'b0;
    RegWrite_o    = 1'b0;
    PCWrite_o     = 1'b0;
    PCWriteCond_o = 1'b0;
    PCSource_o    = PCSRC_ALU;
    illegal_o     = 1'b0;
    case (state)
      S_FETCH: begin
        MemRead_o = 1'b1;
        ALUSrcB_o = SRCB_FOUR;
        IRWrite_o = mem_ready_i;
        PCWrite_o = mem_ready_i;
      end
      S_DECODE: begin
        ALUSrcB_o = SRCB_IMM_SH;
        illegal_o = !op_supported(opcode_i);
      end
      S_MEM_ADDR: begin
        ALUSrcA_o = 1'b1;
        ALUSrcB_o = SRCB_IMM;
      end
      S_MEM_RD: begin
        MemRead_o = 1'b1;
        IorD_o    = 1'b1;
      end
      S_MEM_WR: begin
        MemWrite_o = 1'b1;
        IorD_o     = 1'b1;
      end
      S_MEM_WB: begin
        RegWrite_o = 1'b1;
        MemtoReg_o = 1'b1;
      end
      S_R_EXE: begin
        ALUSrcA_o = 1'b1;
        ALUOp_o   = ALUOP_R;
      end
      S_R_WB: begin
        RegWrite_o = 1'b1;
        RegDst_o   = 1'b1;
      end
      S_I_EXE: begin
        ALUSrcA_o = 1'b1;
        ALUSrcB_o = SRCB_IMM;
        ALUOp_o   = (opcode_i == OP_SLTI) ? ALUOP_SLTI : ALUOP_ADDI;
      end
      S_I_WB:     RegWrite_o = 1'b1;
      S_BRANCH: begin
        ALUSrcA_o     = 1'b1;
        ALUOp_o       = ALUOP_SUB;
        PCWriteCond_o = 1'b1;
        PCSource_o    = PCSRC_ALUOUT;
      end
      S_JUMP: begin
        PCWrite_o  = 1'b1;
        PCSource_o = PCSRC_JUMP;
      end
      default: ;
    endcase
    // Reset abandons the instruction: nothing may be written, PC+4 path selected.
    if (!rst_i) begin
      ALUOp_o       = ALUOP_ADD;
      ALUSrcA_o     = 1'b0;
      ALUSrcB_o     = SRCB_FOUR;
      IorD_o        = 1'b0;
      MemRead_o     = 1'b0;
      MemWrite_o    = 1'b0;
      IRWrite_o     = 1'b0;
      MemtoReg_o    = 1'b0;
      RegDst_o      = 1'b0;
      RegWrite_o    = 1'b0;
      PCWrite_o     = 1'b0;
      PCWriteCond_o = 1'b0;
      PCSource_o    = PCSRC_ALU;
      illegal_o     = 1'b0;
    end
  end

  assign state_o = state;

endmodule

`default_nettype wire

// File: tb/tb_multi_cycle_ctrl.sv
// ============================================================
// tb_multi_cycle_ctrl : instruction-level reference model vs multi_cycle_ctrl
// Rev 1.0
// ============================================================
`default_nettype none

module tb_multi_cycle_ctrl;

  typedef struct {
    logic [3:0] st;
    bit         chk_st;
    bit         rst;
    bit         rdy;
    logic [5:0] op;
    logic [2:0] aluop;
    logic       srca;
    logic [1:0] srcb;
    logic       iord, memrd, memwr, irw, m2r, regdst, regw, pcw, pcwc;
    logic [1:0] pcsrc;
    logic       ill;
  } rec_t;

  logic       clk = 1'b0;
  logic       rst_i = 1'b0;
  logic [5:0] opcode_i = 6'd0;
  logic       mem_ready_i = 1'b1;
  logic [2:0] ALUOp_o;
  logic       ALUSrcA_o;
  logic [1:0] ALUSrcB_o;
  logic       IorD_o, MemRead_o, MemWrite_o, IRWrite_o, MemtoReg_o, RegDst_o;
  logic       RegWrite_o, PCWrite_o, PCWriteCond_o, illegal_o;
  logic [1:0] PCSource_o;
  logic [3:0] state_o;

  int errors = 0;
  int checks = 0;
  rec_t q[$];

  multi_cycle_ctrl #(.OP_W(6), .ST_W(4)) dut (
    .clk_i(clk), .rst_i(rst_i), .opcode_i(opcode_i), .mem_ready_i(mem_ready_i),
    .ALUOp_o(ALUOp_o), .ALUSrcA_o(ALUSrcA_o), .ALUSrcB_o(ALUSrcB_o), .IorD_o(IorD_o),
    .MemRead_o(MemRead_o), .MemWrite_o(MemWrite_o), .IRWrite_o(IRWrite_o),
    .MemtoReg_o(MemtoReg_o), .RegDst_o(RegDst_o), .RegWrite_o(RegWrite_o),
    .PCWrite_o(PCWrite_o), .PCWriteCond_o(PCWriteCond_o), .PCSource_o(PCSource_o),
    .illegal_o(illegal_o), .state_o(state_o)
  );

  always #5 clk = ~clk;

  function automatic bit legal(input logic [5:0] op);
    return op inside {6'd0, 6'd2, 6'd4, 6'd8, 6'd10, 6'd35, 6'd43};
  endfunction

  // One cycle of an instruction: everything idle unless the step sets it.
  function automatic rec_t base(input logic [3:0] st, input logic [5:0] op);
    rec_t r;
    r.st = st; r.chk_st = 1'b1; r.rst = 1'b1; r.rdy = 1'($urandom_range(0, 1)); r.op = op;
    r.aluop = 3'b000; r.srca = 1'b0; r.srcb = 2'b00; r.pcsrc = 2'b00;
    r.iord = 0; r.memrd = 0; r.memwr = 0; r.irw = 0; r.m2r = 0; r.regdst = 0;
    r.regw = 0; r.pcw = 0; r.pcwc = 0; r.ill = 0;
    return r;
  endfunction

  function automatic rec_t as_reset(input rec_t c, input bit chk, input bit rdy);
    rec_t r;
    r = base(c.st, c.op);
    r.chk_st = chk; r.rst = 1'b0; r.rdy = rdy; r.srcb = 2'b01;
    return r;
  endfunction

  // Expand one instruction into its expected cycles; abort_at turns that cycle into a reset.
  task automatic gen_instr(input logic [5:0] op, input int fw, input int mw,
                           input int abort_at, output int n);
    rec_t t[$];
    rec_t r;
    for (int i = 0; i <= fw; i++) begin
      r = base(4'd0, op); r.memrd = 1; r.srcb = 2'b01;
      r.rdy = (i == fw); r.irw = (i == fw); r.pcw = (i == fw);
      t.push_back(r);
    end
    r = base(4'd1, op); r.srcb = 2'b11; r.ill = !legal(op); t.push_back(r);
    if (op == 6'd35 || op == 6'd43) begin
      r = base(4'd2, op); r.srca = 1; r.srcb = 2'b10; t.push_back(r);
      for (int i = 0; i <= mw; i++) begin
        r = base((op == 6'd35) ? 4'd3 : 4'd5, op); r.iord = 1; r.rdy = (i == mw);
        if (op == 6'd35) r.memrd = 1; else r.memwr = 1;
        t.push_back(r);
      end
      if (op == 6'd35) begin
        r = base(4'd4, op); r.regw = 1; r.m2r = 1; t.push_back(r);
      end
    end else if (op == 6'd0) begin
      r = base(4'd6, op); r.srca = 1; r.aluop = 3'b010; t.push_back(r);
      r = base(4'd7, op); r.regw = 1; r.regdst = 1; t.push_back(r);
    end else if (op == 6'd8 || op == 6'd10) begin
      r = base(4'd9, op); r.srca = 1; r.srcb = 2'b10;
      r.aluop = (op == 6'd10) ? 3'b111 : 3'b011; t.push_back(r);
      r = base(4'd10, op); r.regw = 1; t.push_back(r);
    end else if (op == 6'd4) begin
      r = base(4'd8, op); r.srca = 1; r.aluop = 3'b001; r.pcwc = 1; r.pcsrc = 2'b01;
      t.push_back(r);
    end else if (op == 6'd2) begin
      r = base(4'd11, op); r.pcw = 1; r.pcsrc = 2'b10; t.push_back(r);
    end
    n = 0;
    foreach (t[i]) begin
      n++;
      if (i == abort_at) begin
        q.push_back(as_reset(t[i], 1'b1, t[i].rdy));
        break;
      end
      q.push_back(t[i]);
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (time %0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [17:0] pack_exp(input rec_t r);
    return {r.aluop, r.srca, r.srcb, r.iord, r.memrd, r.memwr, r.irw, r.m2r,
            r.regdst, r.regw, r.pcw, r.pcwc, r.pcsrc, r.ill};
  endfunction

  logic [17:0] dut_outs;
  assign dut_outs = {ALUOp_o, ALUSrcA_o, ALUSrcB_o, IorD_o, MemRead_o, MemWrite_o,
                     IRWrite_o, MemtoReg_o, RegDst_o, RegWrite_o, PCWrite_o,
                     PCWriteCond_o, PCSource_o, illegal_o};

  initial begin
    int n;
    int irw_cnt;
    logic [5:0] op;
    rec_t r0;

    r0 = base(4'd0, 6'd0);
    q.push_back(as_reset(r0, 1'b0, 1'b1));
    q.push_back(as_reset(r0, 1'b1, 1'b1));

    // Directed programme; literal cycle counts pin the model itself.
    gen_instr(6'd35, 0, 0, -1, n); check("model_lw_cycles", n, 5);
    gen_instr(6'd0, 2, 0, -1, n);  check("model_r_cycles_2wait", n, 6);
    irw_cnt = 0;
    for (int i = q.size() - 6; i < q.size(); i++) irw_cnt += q[i].irw;
    check("model_r_irwrite_once", irw_cnt, 1);
    check("model_r_irwrite_cycle3", q[q.size() - 4].irw, 1);
    gen_instr(6'd10, 0, 0, -1, n); check("model_slti_cycles", n, 4);
    check("model_slti_aluop", q[q.size() - 2].aluop, 3'b111);
    gen_instr(6'd8, 0, 0, -1, n);  check("model_addi_cycles", n, 4);
    gen_instr(6'd4, 0, 0, -1, n);  check("model_beq_cycles", n, 3);
    gen_instr(6'd2, 0, 0, -1, n);  check("model_j_cycles", n, 3);
    gen_instr(6'd63, 0, 0, -1, n); check("model_illegal_cycles", n, 2);
    check("model_illegal_flag", q[q.size() - 1].ill, 1);
    gen_instr(6'd43, 0, 0, 3, n);  check("model_sw_abort_cycles", n, 4);
    check("model_sw_abort_state", q[q.size() - 1].st, 4'd5);
    gen_instr(6'd43, 1, 2, -1, n); check("model_sw_waits", n, 7);

    for (int k = 0; k < 250; k++) begin
      case ($urandom_range(0, 7))
        0: op = 6'd35; 1: op = 6'd43; 2: op = 6'd0; 3: op = 6'd4;
        4: op = 6'd8;  5: op = 6'd10; 6: op = 6'd2;
        default: begin
          op = 6'($urandom_range(0, 63));
          while (legal(op)) op = 6'($urandom_range(0, 63));
        end
      endcase
      gen_instr(op, $urandom_range(0, 3), $urandom_range(0, 3),
                ($urandom_range(0, 19) == 0) ? $urandom_range(0, 6) : -1, n);
    end

    // Drive one expected cycle at a time; compare mid-cycle, away from the edge.
    foreach (q[i]) begin
      rst_i = q[i].rst;
      mem_ready_i = q[i].rdy;
      opcode_i = q[i].op;
      #2;
      if (q[i].chk_st) check($sformatf("state[%0d]", i), state_o, q[i].st);
      check($sformatf("outs[%0d] st%0d", i, q[i].st), dut_outs, pack_exp(q[i]));
      @(posedge clk);
      #1;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
